// File: rtl/j1_io_hub.sv
// IO hub for the J1 CPU: one-hot decoded GPIO, UART TX FIFO with drain FSM,
// UART RX holding register with overrun tracking, and a free-running tick counter.
module j1_io_hub #(
  parameter int          GPIO_W     = 5,
  parameter logic [15:0] GPIO_INIT  = 16'h0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          TICK_W     = 16
) (
  input  logic              clk,
  input  logic              resetq,
  input  logic              io_rd,
  input  logic              io_wr,
  input  logic [15:0]       mem_addr,
  input  logic [15:0]       dout,
  output logic [15:0]       io_din,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [7:0]        tx_data,
  output logic              tx_wr,
  input  logic              tx_busy,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_rd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEND  = 2'd1;
  localparam logic [1:0] S_GUARD = 2'd2;

  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic [15:0]       io_din_q, io_din_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_wr_q, tx_wr_d;
  logic              rx_rd_q, rx_rd_d;
  logic [7:0]        rx_hold_q, rx_hold_d;
  logic              rx_full_q, rx_full_d;
  logic              rx_ovr_q, rx_ovr_d;
  logic              tx_ovf_q, tx_ovf_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [7:0]        fifo_mem [FIFO_DEPTH];

  logic sel_gpio, sel_gin, sel_uart, sel_stat, sel_tick;
  logic tx_full, tx_empty, push, push_ok, pop;
  logic capture, uart_rd, stat_rd;
  logic [8:0]  cnt_ext;
  logic [15:0] status_val, rd_val;

  assign sel_gpio = mem_addr[0];
  assign sel_gin  = mem_addr[1];
  assign sel_uart = mem_addr[12];
  assign sel_stat = mem_addr[13];
  assign sel_tick = mem_addr[14];

  assign tx_full  = (count_q == FULL_CNT);
  assign tx_empty = (count_q == '0);
  assign push     = io_wr & sel_uart;
  assign push_ok  = push & ~tx_full;
  assign pop      = (state_q == S_SEND);
  assign capture  = rx_valid & ~rx_rd_q;
  assign uart_rd  = io_rd & sel_uart;
  assign stat_rd  = io_rd & sel_stat;
  assign cnt_ext  = 9'(count_q);

  assign status_val = {cnt_ext[7:0], 3'b000, tx_ovf_q, rx_ovr_q, rx_full_q, tx_empty, tx_full};

  // NOTE: every signal gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    rd_val = 16'h0000;
    if (sel_gpio) rd_val = rd_val | 16'(gpio_q);
    if (sel_gin)  rd_val = rd_val | 16'(gpio_in);
    if (sel_uart) rd_val = rd_val | {8'h00, rx_hold_q};
    if (sel_stat) rd_val = rd_val | status_val;
    if (sel_tick) rd_val = rd_val | 16'(tick_q);

    state_d   = state_q;
    tx_wr_d   = 1'b0;
    tx_data_d = tx_data_q;
    case (state_q)
      S_IDLE: if (!tx_empty && !tx_busy) begin
        state_d   = S_SEND;
        tx_wr_d   = 1'b1;
        tx_data_d = fifo_mem[rd_ptr_q];
      end
      S_SEND:  state_d = S_GUARD;
      default: state_d = S_IDLE;
    endcase

    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;

    // A capture coinciding with a CPU read replaces the byte without flagging overrun.
    rx_rd_d   = capture;
    rx_hold_d = capture ? rx_data : rx_hold_q;
    rx_full_d = capture | (rx_full_q & ~uart_rd);
    rx_ovr_d  = (capture & rx_full_q & ~uart_rd) | (rx_ovr_q & ~stat_rd);
    tx_ovf_d  = (push & tx_full) | (tx_ovf_q & ~stat_rd);

    gpio_d   = (io_wr & sel_gpio) ? dout[GPIO_W-1:0] : gpio_q;
    tick_d   = (io_wr & sel_tick) ? dout[TICK_W-1:0] : tick_q + TICK_W'(1);
    io_din_d = io_rd ? rd_val : io_din_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetq) begin
      gpio_q    <= GPIO_INIT[GPIO_W-1:0];
      io_din_q  <= '0;
      tx_data_q <= '0;
      tx_wr_q   <= 1'b0;
      rx_rd_q   <= 1'b0;
      rx_hold_q <= '0;
      rx_full_q <= 1'b0;
      rx_ovr_q  <= 1'b0;
      tx_ovf_q  <= 1'b0;
      tick_q    <= '0;
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      gpio_q    <= gpio_d;
      io_din_q  <= io_din_d;
      tx_data_q <= tx_data_d;
      tx_wr_q   <= tx_wr_d;
      rx_rd_q   <= rx_rd_d;
      rx_hold_q <= rx_hold_d;
      rx_full_q <= rx_full_d;
      rx_ovr_q  <= rx_ovr_d;
      tx_ovf_q  <= tx_ovf_d;
      tick_q    <= tick_d;
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= dout[7:0];
  end

  logic unused_bits;
  assign unused_bits = ^{mem_addr, dout, cnt_ext};

  assign io_din   = io_din_q;
  assign gpio_out = gpio_q;
  assign tx_data  = tx_data_q;
  assign tx_wr    = tx_wr_q;
  assign rx_rd    = rx_rd_q;

endmodule

// File: tb/tb_j1_io_hub.sv
// Self-checking bench for j1_io_hub: decode table, directed multi-cycle sequences,
// and randomized traffic compared against a queue-based behavioural model.
module tb_j1_io_hub;

  localparam int          GPIO_W    = 5;
  localparam int          DEPTH     = 8;
  localparam int          TICK_W    = 16;
  localparam logic [15:0] GPIO_INIT = 16'h0000;

  logic              clk = 1'b0;
  logic              resetq = 1'b0;
  logic              io_rd = 1'b0, io_wr = 1'b0;
  logic [15:0]       mem_addr = '0, dout = '0;
  logic [15:0]       io_din;
  logic [GPIO_W-1:0] gpio_out;
  logic [GPIO_W-1:0] gpio_in = '0;
  logic [7:0]        tx_data;
  logic              tx_wr;
  logic              tx_busy = 1'b1;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rx_rd;

  j1_io_hub #(.GPIO_W(GPIO_W), .GPIO_INIT(GPIO_INIT), .FIFO_DEPTH(DEPTH), .TICK_W(TICK_W)) dut (
    .clk(clk), .resetq(resetq), .io_rd(io_rd), .io_wr(io_wr), .mem_addr(mem_addr),
    .dout(dout), .io_din(io_din), .gpio_out(gpio_out), .gpio_in(gpio_in),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_rd(rx_rd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int tx_cyc[$];
  logic [7:0] tx_byte[$];
  int rx_pulses = 0;

  // Behavioural model state: the TX FIFO is a plain queue, the drain is a countdown.
  logic [15:0]       m_din;
  logic [GPIO_W-1:0] m_gpio;
  int                m_tick;
  logic [7:0]        q[$];
  logic              m_tx_wr;
  logic [7:0]        m_tx_data;
  int                m_hold;
  logic [7:0]        m_rx_hold;
  logic              m_rx_full, m_ovr, m_ovf, m_rx_rd;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic logic [15:0] m_status();
    int n = q.size();
    return {8'(n), 3'b000, m_ovf, m_ovr, m_rx_full, logic'(n == 0), logic'(n == DEPTH)};
  endfunction

  task automatic model_edge();
    logic [15:0] v;
    logic full_pre, start, cap, urd, srd, ovr_set, ovf_set;
    logic [7:0] head;
    if (!resetq) begin
      m_din = '0; m_gpio = GPIO_INIT[GPIO_W-1:0]; m_tick = 0; q.delete();
      m_tx_wr = 1'b0; m_tx_data = '0; m_hold = 0; m_rx_hold = '0;
      m_rx_full = 1'b0; m_ovr = 1'b0; m_ovf = 1'b0; m_rx_rd = 1'b0;
      return;
    end
    v = '0;
    if (mem_addr[0])  v |= 16'(m_gpio);
    if (mem_addr[1])  v |= 16'(gpio_in);
    if (mem_addr[12]) v |= {8'h00, m_rx_hold};
    if (mem_addr[13]) v |= m_status();
    if (mem_addr[14]) v |= 16'(m_tick);

    full_pre = (q.size() == DEPTH);
    start    = (m_hold == 0) && (q.size() != 0) && !tx_busy;
    head     = (q.size() != 0) ? q[0] : 8'h00;
    if (m_tx_wr) void'(q.pop_front());
    ovf_set = 1'b0;
    if (io_wr && mem_addr[12]) begin
      if (full_pre) ovf_set = 1'b1;
      else q.push_back(dout[7:0]);
    end
    if (m_hold > 0) m_hold--;
    if (start) begin m_hold = 2; m_tx_data = head; end
    m_tx_wr = start;

    cap     = rx_valid && !m_rx_rd;
    urd     = io_rd && mem_addr[12];
    srd     = io_rd && mem_addr[13];
    ovr_set = cap && m_rx_full && !urd;
    if (cap) m_rx_hold = rx_data;
    m_rx_full = cap || (m_rx_full && !urd);
    m_rx_rd   = cap;
    m_ovr     = ovr_set || (m_ovr && !srd);
    m_ovf     = ovf_set || (m_ovf && !srd);

    if (io_wr && mem_addr[14]) m_tick = int'(dout) % (1 << TICK_W);
    else m_tick = (m_tick + 1) % (1 << TICK_W);
    if (io_wr && mem_addr[0]) m_gpio = dout[GPIO_W-1:0];
    if (io_rd) m_din = v;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc_n++;
    if (tx_wr) begin tx_cyc.push_back(cyc_n); tx_byte.push_back(tx_data); end
    if (rx_rd) rx_pulses++;
    check("model_io_din", io_din, m_din);
    check("model_gpio", 16'(gpio_out), 16'(m_gpio));
    check("model_tx_wr", 16'(tx_wr), 16'(m_tx_wr));
    check("model_tx_data", 16'(tx_data), 16'(m_tx_data));
    check("model_rx_rd", 16'(rx_rd), 16'(m_rx_rd));
  endtask

  task automatic bus(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] data);
    io_rd = rd; io_wr = wr; mem_addr = addr; dout = data;
    step();
    io_rd = 1'b0; io_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    resetq = 1'b0; io_rd = 1'b0; io_wr = 1'b0; rx_valid = 1'b0;
    step(); step();
    resetq = 1'b1;
  endtask

  task automatic wait_tx(input string name);
    for (int i = 0; i < 20 && !tx_wr; i++) step();
    check(name, 16'(tx_wr), 16'h0001);
  endtask

  typedef struct {
    logic rd; logic wr; logic [15:0] addr; logic [15:0] data; logic [GPIO_W-1:0] gin;
    logic [15:0] exp_din; logic [GPIO_W-1:0] exp_gpio;
  } vec_t;

  vec_t tbl[10];
  logic [15:0] addrs[10];

  initial begin
    tbl[0] = '{1'b0, 1'b1, 16'h0001, 16'h0015, 5'h00, 16'h0000, 5'h15};
    tbl[1] = '{1'b1, 1'b0, 16'h0001, 16'h0000, 5'h00, 16'h0015, 5'h15};
    tbl[2] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 5'h0A, 16'h000A, 5'h15};
    tbl[3] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 5'h0A, 16'h001F, 5'h15};
    tbl[4] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 5'h0A, 16'h0000, 5'h15};
    tbl[5] = '{1'b1, 1'b0, 16'h2000, 16'h0000, 5'h00, 16'h0002, 5'h15};
    tbl[6] = '{1'b1, 1'b1, 16'h0001, 16'h0003, 5'h00, 16'h0015, 5'h03};
    tbl[7] = '{1'b0, 1'b0, 16'h0001, 16'h0000, 5'h1F, 16'h0015, 5'h03};
    tbl[8] = '{1'b1, 1'b0, 16'h0800, 16'h0000, 5'h1F, 16'h0000, 5'h03};
    tbl[9] = '{1'b0, 1'b1, 16'h0001, 16'hFFE0, 5'h00, 16'h0000, 5'h00};
    addrs = '{16'h0001, 16'h0002, 16'h1000, 16'h2000, 16'h4000,
              16'h3000, 16'h0003, 16'h0000, 16'h5001, 16'hFFFF};

    do_reset();
    check("reset_io_din", io_din, 16'h0000);
    check("reset_gpio", 16'(gpio_out), GPIO_INIT);
    check("reset_tx_wr", 16'(tx_wr), 16'h0000);
    check("reset_rx_rd", 16'(rx_rd), 16'h0000);
    check("reset_tx_data", 16'(tx_data), 16'h0000);

    // Decode / GPIO table.
    tx_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      gpio_in = tbl[i].gin;
      bus(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data);
      check($sformatf("tbl%0d_io_din", i), io_din, tbl[i].exp_din);
      check($sformatf("tbl%0d_gpio", i), 16'(gpio_out), 16'(tbl[i].exp_gpio));
    end

    // Two bytes drained with the guard gap in between.
    do_reset();
    tx_busy = 1'b0;
    tx_cyc.delete(); tx_byte.delete();
    bus(1'b0, 1'b1, 16'h1000, 16'h0041);
    bus(1'b0, 1'b1, 16'h1000, 16'h0042);
    idle(10);
    check("tx_pulse_count", 16'(tx_cyc.size()), 16'h0002);
    if (tx_cyc.size() >= 2) begin
      check("tx_byte0", 16'(tx_byte[0]), 16'h0041);
      check("tx_byte1", 16'(tx_byte[1]), 16'h0042);
      check("tx_gap_ge3", 16'(tx_cyc[1] - tx_cyc[0] >= 3), 16'h0001);
    end
    bus(1'b1, 1'b0, 16'h2000, 16'h0000);
    check("tx_empty_after", io_din & 16'h0002, 16'h0002);

    // Overflow with a busy transmitter, then sticky clear on read.
    do_reset();
    tx_busy = 1'b1;
    for (int i = 0; i < 9; i++) bus(1'b0, 1'b1, 16'h1000, 16'(8'hA0 + i));
    bus(1'b1, 1'b0, 16'h2000, 16'h0000);
    check("ovf_status", io_din, 16'h0811);
    bus(1'b1, 1'b0, 16'h2000, 16'h0000);
    check("ovf_cleared", io_din, 16'h0801);

    // Push on a full FIFO in the same cycle as a pop is still dropped.
    tx_busy = 1'b0;
    wait_tx("wait_send_full");
    tx_busy = 1'b1;
    bus(1'b0, 1'b1, 16'h1000, 16'h0099);
    bus(1'b1, 1'b0, 16'h2000, 16'h0000);
    check("ovf_with_pop", io_din, 16'h0710);

    // RX overrun without a CPU read.
    do_reset();
    rx_pulses = 0;
    rx_valid = 1'b1; rx_data = 8'h55; step();
    rx_valid = 1'b0; step();
    rx_valid = 1'b1; rx_data = 8'h66; step();
    rx_valid = 1'b0; step();
    check("rx_pulses", 16'(rx_pulses), 16'h0002);
    bus(1'b1, 1'b0, 16'h1000, 16'h0000);
    check("rx_read_66", io_din, 16'h0066);
    bus(1'b1, 1'b0, 16'h2000, 16'h0000);
    check("rx_overrun_status", io_din, 16'h000A);

    // Overrun event coinciding with the STATUS read stays set.
    do_reset();
    rx_valid = 1'b1; rx_data = 8'h11; step();
    rx_valid = 1'b0; step();
    rx_valid = 1'b1; rx_data = 8'h22; io_rd = 1'b1; mem_addr = 16'h2000; step();
    rx_valid = 1'b0; io_rd = 1'b0;
    check("sticky_pre_read", io_din, 16'h0006);
    bus(1'b1, 1'b0, 16'h2000, 16'h0000);
    check("sticky_survives", io_din, 16'h000E);
    bus(1'b1, 1'b0, 16'h2000, 16'h0000);
    check("sticky_cleared", io_din, 16'h0006);

    // Capture coinciding with a UART_DATA read: old byte returned, no overrun.
    do_reset();
    rx_valid = 1'b1; rx_data = 8'h33; step();
    rx_valid = 1'b0; step();
    rx_valid = 1'b1; rx_data = 8'h44; io_rd = 1'b1; mem_addr = 16'h1000; step();
    rx_valid = 1'b0; io_rd = 1'b0;
    check("rx_coinc_old", io_din, 16'h0033);
    bus(1'b1, 1'b0, 16'h2000, 16'h0000);
    check("rx_coinc_status", io_din, 16'h0006);
    bus(1'b1, 1'b0, 16'h1000, 16'h0000);
    check("rx_coinc_new", io_din, 16'h0044);
    bus(1'b1, 1'b0, 16'h2000, 16'h0000);
    check("rx_coinc_empty", io_din, 16'h0002);

    // TICK wrap.
    bus(1'b0, 1'b1, 16'h4000, 16'hFFFE);
    idle(3);
    bus(1'b1, 1'b0, 16'h4000, 16'h0000);
    check("tick_wrap", io_din, 16'h0001);

    // Reset during SEND with bytes queued.
    do_reset();
    tx_busy = 1'b1;
    bus(1'b0, 1'b1, 16'h0001, 16'h000A);
    for (int i = 0; i < 3; i++) bus(1'b0, 1'b1, 16'h1000, 16'(8'h70 + i));
    tx_busy = 1'b0;
    wait_tx("wait_send_reset");
    resetq = 1'b0; step(); resetq = 1'b1;
    check("rst_send_tx_wr", 16'(tx_wr), 16'h0000);
    check("rst_send_gpio", 16'(gpio_out), GPIO_INIT);
    tx_cyc.delete(); tx_byte.delete();
    bus(1'b1, 1'b0, 16'h2000, 16'h0000);
    check("rst_send_status", io_din, 16'h0002);
    idle(6);
    check("rst_send_no_tx", 16'(tx_cyc.size()), 16'h0000);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      mem_addr = addrs[$urandom_range(0, 9)];
      io_rd    = ($urandom_range(0, 9) < 4);
      io_wr    = ($urandom_range(0, 9) < 3);
      dout     = 16'($urandom);
      gpio_in  = GPIO_W'($urandom);
      tx_busy  = ($urandom_range(0, 1) == 1);
      rx_valid = ($urandom_range(0, 1) == 1);
      rx_data  = 8'($urandom);
      resetq   = ($urandom_range(0, 499) != 0);
      step();
    end
    resetq = 1'b1; io_rd = 1'b0; io_wr = 1'b0; rx_valid = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
